tcdm_initiator_adapter: RTL and testbench

Initiator-side adapter that drives one master port of the TCDM crossbar: req/add/wen/wdata/be out, gnt/rvld/rdata in. It converts an upstream valid/ready request stream into the crossbar's req-hold-until-gnt protocol. Responses (rvld exactly 1 cycle after gnt) are captured into a credit-protected response FIFO, so the crossbar never has to stall a response. One instance sits between each core/DMA port and the crossbar.

---
 rtl/tcdm_initiator_adapter.sv | 181 ++++++++++++++++++
 tb/tb_tcdm_initiator_adapter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_initiator_adapter.sv
// rtl/tcdm_initiator_adapter.sv - TCDM crossbar initiator adapter (valid/ready to req/gnt, credit-protected response FIFO)
// Optional: define TCDM_INIT_RESP_BYPASS_EN for a zero-latency response path when the FIFO is empty.
module tcdm_initiator_adapter #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned BeWidth   = DataWidth / 8,
    parameter int unsigned MetaWidth = 4,
    parameter int unsigned RespDepth = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic                 req_wen_i,
    input  logic [DataWidth-1:0] req_wdata_i,
    input  logic [BeWidth-1:0]   req_be_i,
    input  logic [MetaWidth-1:0] req_meta_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic [DataWidth-1:0] resp_rdata_o,
    output logic [MetaWidth-1:0] resp_meta_o,
    output logic                 req_o,
    output logic [AddrWidth-1:0] add_o,
    output logic                 wen_o,
    output logic [DataWidth-1:0] wdata_o,
    output logic [BeWidth-1:0]   be_o,
    input  logic                 gnt_i,
    input  logic                 rvld_i,
    input  logic [DataWidth-1:0] rdata_i,
    output logic                 err_o
);

    localparam int unsigned PtrW = (RespDepth > 1) ? $clog2(RespDepth) : 1;
    localparam int unsigned CntW = $clog2(RespDepth + 1);
    localparam logic [CntW-1:0] DepthC  = CntW'(RespDepth);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(RespDepth - 1);

    // Request hold slot: what the crossbar currently sees
    logic                 slot_valid;
    logic [AddrWidth-1:0] slot_addr;
    logic                 slot_wen;
    logic [DataWidth-1:0] slot_wdata;
    logic [BeWidth-1:0]   slot_be;
    logic [MetaWidth-1:0] slot_meta;

    // Request granted last cycle; its response is due now
    logic                 inflight;
    logic [MetaWidth-1:0] inflight_meta;

    // Response FIFO storage and pointers
    logic [DataWidth-1:0] fifo_data [RespDepth];
    logic [MetaWidth-1:0] fifo_meta [RespDepth];
    logic [PtrW-1:0]      wr_ptr;
    logic [PtrW-1:0]      rd_ptr;
    logic [CntW-1:0]      fifo_cnt;

    // Credits: requests accepted whose response has not yet been popped
    logic [CntW-1:0]      used;
    logic                 err;

    logic grant;
    logic accept;
    logic fifo_empty;
    logic rsp_in;
    logic bypass;
    logic push;
    logic fifo_pop;
    logic resp_pop;

    assign grant       = slot_valid & gnt_i;
    assign req_ready_o = !rst_i && (used < DepthC) && (!slot_valid || gnt_i);
    assign accept      = req_valid_i & req_ready_o;
    assign fifo_empty  = (fifo_cnt == '0);
    assign rsp_in      = rvld_i & inflight;

`ifdef TCDM_INIT_RESP_BYPASS_EN
    assign bypass = rsp_in & fifo_empty & resp_ready_i;
`else
    assign bypass = 1'b0;
`endif

    assign push     = rsp_in & !bypass;
    assign fifo_pop = !fifo_empty & resp_ready_i;
    assign resp_pop = fifo_pop | bypass;

    assign resp_valid_o = !fifo_empty | bypass;
    assign resp_rdata_o = bypass ? rdata_i : fifo_data[rd_ptr];
    assign resp_meta_o  = bypass ? inflight_meta : fifo_meta[rd_ptr];

    assign req_o   = slot_valid;
    assign add_o   = slot_addr;
    assign wen_o   = slot_wen;
    assign wdata_o = slot_wdata;
    assign be_o    = slot_be;
    assign err_o   = err;

    // Slot loads on accept (possibly in the same cycle its occupant is granted) and empties on grant
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_valid <= 1'b0;
            slot_addr  <= '0;
            slot_wen   <= 1'b0;
            slot_wdata <= '0;
            slot_be    <= '0;
            slot_meta  <= '0;
        end else if (accept) begin
            slot_valid <= 1'b1;
            slot_addr  <= req_addr_i;
            slot_wen   <= req_wen_i;
            slot_wdata <= req_wdata_i;
            slot_be    <= req_be_i;
            slot_meta  <= req_meta_i;
        end else if (grant) begin
            slot_valid <= 1'b0;
        end
    end

    // In-flight tracker: a grant always expects rvld exactly one cycle later
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight      <= 1'b0;
            inflight_meta <= '0;
        end else begin
            inflight <= grant;
            if (grant) begin
                inflight_meta <= slot_meta;
            end
        end
    end

    // Sticky error on unexpected or missing response; a missed response leaks its credit
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err <= 1'b0;
        end else if ((rvld_i && !inflight) || (inflight && !rvld_i)) begin
            err <= 1'b1;
        end
    end

    // Credit counter: up on accept, down on response pop
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            used <= '0;
        end else begin
            case ({accept, resp_pop})
                2'b10:   used <= used + CntW'(1);
                2'b01:   used <= used - CntW'(1);
                default: used <= used;
            endcase
        end
    end

    // Response FIFO; credits guarantee a push never finds it full unless a pop happens too
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < int'(RespDepth); i++) begin
                fifo_data[i] <= '0;
                fifo_meta[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= rdata_i;
                fifo_meta[wr_ptr] <= inflight_meta;
                wr_ptr <= (wr_ptr == LastPtr) ? '0 : wr_ptr + PtrW'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + PtrW'(1);
            end
            case ({push, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + CntW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CntW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_tcdm_initiator_adapter.sv
// tb/tb_tcdm_initiator_adapter.sv - directed self-checking bench for tcdm_initiator_adapter
module tb_tcdm_initiator_adapter;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic        req_wen_i = 1'b0;
    logic [31:0] req_wdata_i = '0;
    logic [3:0]  req_be_i = '0;
    logic [3:0]  req_meta_i = '0;
    logic        resp_ready_i = 1'b0;
    logic        gnt_i = 1'b0;
    logic        rvld_i = 1'b0;
    logic [31:0] rdata_i = '0;

    // Instance a: RespDepth=2; instance b: RespDepth=4 for full-rate streaming
    logic        req_ready_a, req_a, wen_a, resp_valid_a, err_a;
    logic [31:0] add_a, wdata_a, resp_rdata_a;
    logic [3:0]  be_a, resp_meta_a;
    logic        req_ready_b, req_b, wen_b, resp_valid_b, err_b;
    logic [31:0] add_b, wdata_b, resp_rdata_b;
    logic [3:0]  be_b, resp_meta_b;

    logic sel = 1'b0;
    logic        rdy_o, rq_o, rv_o, er_o;
    logic [31:0] ad_o, rd_o;
    logic [3:0]  rm_o;
    assign rdy_o = sel ? req_ready_b  : req_ready_a;
    assign rq_o  = sel ? req_b        : req_a;
    assign ad_o  = sel ? add_b        : add_a;
    assign rv_o  = sel ? resp_valid_b : resp_valid_a;
    assign rd_o  = sel ? resp_rdata_b : resp_rdata_a;
    assign rm_o  = sel ? resp_meta_b  : resp_meta_a;
    assign er_o  = sel ? err_b        : err_a;

    always #5 clk = ~clk;

    tcdm_initiator_adapter #(.RespDepth(2)) dut_a (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_a), .req_addr_i(req_addr_i),
        .req_wen_i(req_wen_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i), .req_meta_i(req_meta_i),
        .resp_valid_o(resp_valid_a), .resp_ready_i(resp_ready_i), .resp_rdata_o(resp_rdata_a), .resp_meta_o(resp_meta_a),
        .req_o(req_a), .add_o(add_a), .wen_o(wen_a), .wdata_o(wdata_a), .be_o(be_a),
        .gnt_i(gnt_i), .rvld_i(rvld_i), .rdata_i(rdata_i), .err_o(err_a)
    );

    tcdm_initiator_adapter #(.RespDepth(4)) dut_b (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_b), .req_addr_i(req_addr_i),
        .req_wen_i(req_wen_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i), .req_meta_i(req_meta_i),
        .resp_valid_o(resp_valid_b), .resp_ready_i(resp_ready_i), .resp_rdata_o(resp_rdata_b), .resp_meta_o(resp_meta_b),
        .req_o(req_b), .add_o(add_b), .wen_o(wen_b), .wdata_o(wdata_b), .be_o(be_b),
        .gnt_i(gnt_i), .rvld_i(rvld_i), .rdata_i(rdata_i), .err_o(err_b)
    );

    int vectors = 0;
    int miscompares = 0;

    // Crossbar/memory model state and per-cycle observations
    logic        pend_rvld = 1'b0;
    logic [31:0] pend_rdata = '0;
    logic        force_rvld = 1'b0;
    logic        drop_rvld = 1'b0;
    logic        acc, rdy, popped;
    logic [3:0]  pop_meta;
    logic [31:0] pop_data;

    logic [3:0]  exp_meta [$];
    logic [31:0] exp_addr [$];
    int          acc_at_hold, first_acc, last_acc;
    logic        rdy_at_hold;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : ~a;
    endfunction

    // One clock cycle: drive at the falling edge, sample 1ns later
    task automatic cyc(input logic v, input logic [31:0] a, input logic [3:0] m,
                       input logic w, input logic g, input logic rr);
        @(negedge clk);
        req_valid_i  = v;
        req_addr_i   = a;
        req_meta_i   = m;
        req_wen_i    = w;
        req_wdata_i  = a ^ 32'h5A5A5A5A;
        req_be_i     = 4'hF;
        gnt_i        = g;
        resp_ready_i = rr;
        rvld_i       = (pend_rvld & !drop_rvld) | force_rvld;
        rdata_i      = pend_rdata;
        #1;
        rdy        = rdy_o;
        acc        = req_valid_i & rdy_o;
        popped     = rv_o & resp_ready_i;
        pop_meta   = rm_o;
        pop_data   = rd_o;
        pend_rvld  = rq_o & gnt_i;
        pend_rdata = rd_of(ad_o);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_i = 1'b1;
        req_valid_i = 1'b0;
        gnt_i = 1'b0;
        rvld_i = 1'b0;
        resp_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        pend_rvld = 1'b0;
    endtask

    // Stream n requests with grant always high; responses held off for the first `hold` cycles
    task automatic run(input int n, input int hold, input int budget);
        int nxt = 0;
        int got = 0;
        int cy = 0;
        logic [31:0] a;
        exp_meta.delete();
        exp_addr.delete();
        while (got < n && cy < budget) begin
            a = 32'(32'h400 + nxt * 4);
            cyc(nxt < n, a, 4'(nxt), nxt[0], 1'b1, cy >= hold);
            if (popped) begin
                if (exp_meta.size() == 0) begin
                    chk("resp_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("resp_meta", 32'(pop_meta), 32'(exp_meta.pop_front()));
                    chk("resp_rdata", pop_data, rd_of(exp_addr.pop_front()));
                end
                got++;
            end
            if (acc) begin
                exp_meta.push_back(4'(nxt));
                exp_addr.push_back(a);
                if (nxt == 0) first_acc = cy;
                if (nxt == n - 1) last_acc = cy;
                nxt++;
            end
            if (cy == hold - 1) begin
                acc_at_hold = nxt;
                rdy_at_hold = rdy;
            end
            cy++;
        end
        chk("drain_count", 32'(got), 32'(n));
        chk("err_clean", 32'(er_o), 32'd0);
    endtask

    initial begin
        // Reset values
        @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(rdy_o), 32'd0);
        chk("rst_req", 32'(rq_o), 32'd0);
        chk("rst_resp_valid", 32'(rv_o), 32'd0);
        chk("rst_err", 32'(er_o), 32'd0);
        chk("rst_add", add_a, 32'd0);
        chk("rst_wdata", wdata_a, 32'd0);
        chk("rst_be", 32'(be_a), 32'd0);
        chk("rst_wen", 32'(wen_a), 32'd0);
        chk("rst_rdata", rd_o, 32'd0);
        chk("rst_meta", 32'(rm_o), 32'd0);
        reset_dut();

        // Single load
        cyc(1'b1, 32'h100, 4'd3, 1'b1, 1'b0, 1'b1);
        chk("ld_accept", 32'(acc), 32'd1);
        cyc(1'b0, 32'h100, 4'd3, 1'b1, 1'b1, 1'b1);
        chk("ld_req", 32'(rq_o), 32'd1);
        chk("ld_add", ad_o, 32'h100);
        chk("ld_wen", 32'(wen_a), 32'd1);
        cyc(1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b1);
        chk("ld_req_dropped", 32'(rq_o), 32'd0);
`ifdef TCDM_INIT_RESP_BYPASS_EN
        chk("ld_byp_valid", 32'(rv_o), 32'd1);
        chk("ld_byp_rdata", rd_o, 32'hDEADBEEF);
        chk("ld_byp_meta", 32'(rm_o), 32'd3);
        cyc(1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b1);
        chk("ld_byp_no_dup", 32'(rv_o), 32'd0);
`else
        chk("ld_not_yet", 32'(rv_o), 32'd0);
        cyc(1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b1);
        chk("ld_valid", 32'(rv_o), 32'd1);
        chk("ld_rdata", rd_o, 32'hDEADBEEF);
        chk("ld_meta", 32'(rm_o), 32'd3);
`endif
        chk("ld_err", 32'(er_o), 32'd0);
        cyc(1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b1);
        chk("ld_popped", 32'(rv_o), 32'd0);

        // Grant stall on a store
        cyc(1'b1, 32'h200, 4'd5, 1'b0, 1'b0, 1'b1);
        chk("st_accept", 32'(acc), 32'd1);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 32'h300, 4'd6, 1'b1, 1'b0, 1'b1);
            chk("stall_req", 32'(rq_o), 32'd1);
            chk("stall_add", ad_o, 32'h200);
            chk("stall_wdata", wdata_a, 32'h5A5A585A);
            chk("stall_be", 32'(be_a), 32'hF);
            chk("stall_wen", 32'(wen_a), 32'd0);
            chk("stall_ready", 32'(rdy), 32'd0);
        end
        cyc(1'b0, 32'h0, 4'd0, 1'b0, 1'b1, 1'b1);
        chk("stall_gnt_add", ad_o, 32'h200);
        cyc(1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b1);
        chk("stall_req_dropped", 32'(rq_o), 32'd0);
`ifdef TCDM_INIT_RESP_BYPASS_EN
        chk("st_byp_valid", 32'(rv_o), 32'd1);
        chk("st_byp_meta", 32'(rm_o), 32'd5);
        chk("st_byp_rdata", rd_o, 32'hFFFFFDFF);
`else
        cyc(1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b1);
        chk("st_valid", 32'(rv_o), 32'd1);
        chk("st_meta", 32'(rm_o), 32'd5);
        chk("st_rdata", rd_o, 32'hFFFFFDFF);
`endif
        cyc(1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b1);
        chk("st_popped", 32'(rv_o), 32'd0);
        chk("st_err", 32'(er_o), 32'd0);

        // Backpressure: depth 2, four requests, responses held for 6 cycles
        run(4, 6, 40);
        chk("bp_accepted", 32'(acc_at_hold), 32'd2);
        chk("bp_ready_low", 32'(rdy_at_hold), 32'd0);

        // Spurious rvld
        reset_dut();
        force_rvld = 1'b1;
        cyc(1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b1);
        force_rvld = 1'b0;
        chk("spur_err_not_yet", 32'(er_o), 32'd0);
        cyc(1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b1);
        chk("spur_err", 32'(er_o), 32'd1);
        repeat (3) cyc(1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b1);
        chk("spur_err_sticky", 32'(er_o), 32'd1);
        reset_dut();
        cyc(1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b1);
        chk("err_cleared", 32'(er_o), 32'd0);

        // Missed response
        cyc(1'b1, 32'h600, 4'd9, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 4'd0, 1'b0, 1'b1, 1'b1);
        drop_rvld = 1'b1;
        cyc(1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b1);
        drop_rvld = 1'b0;
        chk("miss_err_not_yet", 32'(er_o), 32'd0);
        cyc(1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b1);
        chk("miss_err", 32'(er_o), 32'd1);
        chk("miss_no_resp", 32'(rv_o), 32'd0);

        // Reset with slot full and one FIFO entry
        reset_dut();
        cyc(1'b1, 32'h500, 4'd7, 1'b1, 1'b0, 1'b0);
        chk("mr_acc_a", 32'(acc), 32'd1);
        cyc(1'b1, 32'h504, 4'd8, 1'b1, 1'b1, 1'b0);
        chk("mr_acc_b", 32'(acc), 32'd1);
        cyc(1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("mr_slot_full", 32'(rq_o), 32'd1);
        chk("mr_fifo_one", 32'(rv_o), 32'd1);
        @(negedge clk);
        rst_i = 1'b1;
        req_valid_i = 1'b0;
        #1;
        chk("mr_ready_in_rst", 32'(rdy_o), 32'd0);
        @(negedge clk);
        rst_i = 1'b0;
        pend_rvld = 1'b0;
        #1;
        chk("mr_req", 32'(rq_o), 32'd0);
        chk("mr_resp_valid", 32'(rv_o), 32'd0);
        chk("mr_err", 32'(er_o), 32'd0);
        run(3, 5, 40);
        chk("mr_credits_full", 32'(acc_at_hold), 32'd2);

        // Streaming on the depth-4 instance
        sel = 1'b1;
        reset_dut();
        run(16, 0, 80);
        chk("stream_rate", 32'(last_acc - first_acc), 32'd15);
        run(6, 8, 60);
        chk("stream_used_zero", 32'(acc_at_hold), 32'd4);
        chk("stream_ready_low", 32'(rdy_at_hold), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
